mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Consumes the ALU result: the effective address for ld/st, where the ALU computes a+b, or the final value for all other ops.
- Performs the single-beat data-memory transaction for ld/st over a req/ack bus, with a timeout, and issues one writeback record per instruction.
- Stalls the upstream execute stage while a bus transaction is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- RD_W, 4, destination register index width (16 GPRs).
- TIMEOUT, 16, max cycles in BUS without mem_ack before abort (>=2).
- CNT_W, $clog2(TIMEOUT), timeout counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid  in  1  execute-stage record valid this cycle.
- ex_result  in  DATA_W  ALU result: address for ld/st, value otherwise.
- ex_store_data  in  DATA_W  register value to store (st only).
- ex_is_ld  in  1  instruction is load.
- ex_is_st  in  1  instruction is store.
- ex_rd  in  RD_W  destination register.
- ex_wb_en  in  1  instruction writes a register.
- stall  out  1  upstream must hold all ex_* inputs stable while high.
- mem_req  out  1  bus request, held until ack or timeout.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_W  word address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  single-cycle completion strobe.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- wb_valid  out  1  one-cycle pulse, one per accepted instruction.
- wb_en  out  1  write wb_data to wb_rd.
- wb_rd  out  RD_W  destination register.
- wb_data  out  DATA_W  ALU value or load data.
- wb_err  out  1  instruction faulted; wb_en forced 0.

Behaviour:
- Reset: synchronous on rst_n=0 at the clk edge.
  - All outputs go to 0, the FSM goes to IDLE and the counter clears.
  - Reset during BUS drops mem_req on the next edge; no wb_valid is issued for the aborted instruction.
- Combinational outputs: stall = (state==BUS) and mem_req = (state==BUS). All other outputs are registered.
- IDLE, ex_valid=1, neither ld nor st: next edge drives wb_valid=1, wb_data=ex_result, wb_rd=ex_rd, wb_en=ex_wb_en, wb_err=0. Latency is 1 cycle, throughput 1/cycle.
- IDLE, ex_valid=1, exactly one of ld/st, ex_result[1:0]==0:
  - Latch mem_addr=ex_result, mem_we=ex_is_st, mem_wdata=ex_store_data, rd and wb_en; clear the counter; go to BUS.
  - wb_valid=0 that edge.
- IDLE, ex_valid=1, misaligned (ex_result[1:0]!=0) or ld and st both set:
  - No bus access.
  - Next edge gives wb_valid=1, wb_err=1, wb_en=0, wb_data=ex_result.
- IDLE, ex_valid=0: wb_valid=0, and wb_* data fields hold.
- BUS: mem_addr, mem_we and mem_wdata are stable; the counter increments each cycle.
  - mem_ack=1: go to IDLE next edge with wb_valid=1, wb_err=0, wb_rd=latched rd.
    - Load: wb_data=mem_rdata, wb_en=1.
    - Store: wb_data=mem_addr, wb_en=0.
  - mem_ack=0 and counter==TIMEOUT-1: go to IDLE with wb_valid=1, wb_err=1, wb_en=0, wb_data=mem_addr.
  - mem_ack and timeout in the same cycle: ack wins.
  - ex_* inputs are ignored in BUS; upstream holds the next instruction, which is accepted in the first IDLE cycle.
- Memory op latency: 1 accept cycle + N request cycles (N>=1, N = cycle of ack); wb_valid comes on the edge after ack.
- mem_ack while in IDLE is ignored.
- Each accepted instruction produces exactly one wb_valid pulse.

Decomposition:
- Shared package mem_stage_pkg holds:
  - the state enum: IDLE, BUS;
  - the width constants DATA_W and RD_W;
  - the localparam TIMEOUT default.
- One sub-module, bus_timeout_ctr: clear, enable, expired-at-TIMEOUT-1, synchronous active-low reset.
- The FSM and the writeback registers stay in mem_access_stage.

Test Plan:
- ALU ops back-to-back with ex_result=0x10, 0x20, 0x30 -> wb_valid high on 3 consecutive cycles, wb_data 0x10/0x20/0x30, stall never high.
- ld addr 0x100, mem_ack on 3rd BUS cycle with rdata 0xDEADBEEF -> stall high 3 cycles; wb_valid one cycle later with wb_data=0xDEADBEEF, wb_en=1, wb_err=0.
- st addr 0x204, data 0x55 -> mem_we=1, mem_addr=0x204, mem_wdata=0x55 held until ack; then wb_valid=1, wb_en=0.
- ld addr 0x102 (misaligned) -> mem_req never asserted; wb_valid=1, wb_err=1 one cycle later.
- ld with no ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, then wb_err=1, wb_en=0; ack plus expiry in the same cycle -> wb_err=0.
- rst_n=0 on BUS cycle 2 -> mem_req, stall and wb_valid all 0 after the edge; FSM in IDLE; no writeback for that ld.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and default sizes for the memory-access pipeline stage.
// Contents: FSM state enum, data/register widths, default bus timeout.
// No logic; imported by mem_access_stage and bus_timeout_ctr.
package mem_stage_pkg;

    localparam int MEM_DATA_W  = 32;  // data and address width
    localparam int MEM_RD_W    = 4;   // destination register index width
    localparam int MEM_TIMEOUT = 16;  // max BUS cycles without ack

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Bus-wait counter: counts cycles spent waiting for a memory ack.
// Ports: clk, rst_n (sync, active-low), clr (restart at 0), en (count), expired.
// expired is combinational and high while the count equals TIMEOUT-1.
module bus_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // clr has priority so a new transaction always starts from zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // First BUS cycle sees count 0, so expiry lands on BUS cycle TIMEOUT
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage after the ALU: forwards ALU values or performs one
// single-beat ld/st bus transaction (with timeout), issuing one writeback each.
// Ports: ex_* from execute, stall back to execute, mem_* bus, wb_* writeback.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int RD_W    = MEM_RD_W,
    parameter int TIMEOUT = MEM_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_is_ld,
    input  logic              ex_is_st,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              ex_wb_en,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err
);

    state_t          state;
    state_t          state_nxt;
    logic            mem_op;
    logic            fault;
    logic            start_bus;
    logic            bus_done;
    logic            expired;
    logic [RD_W-1:0] rd_q;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_bus),
        .en      (state == BUS),
        .expired (expired)
    );

    // Decode and next-state logic
    always_comb begin
        mem_op    = ex_is_ld | ex_is_st;
        // ld+st together is malformed; memory ops must be word aligned
        fault     = (ex_is_ld & ex_is_st) | (mem_op & (ex_result[1:0] != 2'b00));
        start_bus = (state == IDLE) & ex_valid & mem_op & ~fault;
        // ack wins over a simultaneous expiry (resolved in the wb registers)
        bus_done  = (state == BUS) & (mem_ack | expired);
        state_nxt = state;
        case (state)
            IDLE:    if (start_bus) state_nxt = BUS;
            BUS:     if (bus_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Upstream is frozen for exactly the cycles a request is on the bus
    assign stall   = (state == BUS);
    assign mem_req = (state == BUS);

    // Bus request fields and writeback registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= '0;
            wb_valid  <= 1'b0;
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (state == IDLE) begin
                if (ex_valid) begin
                    if (!mem_op) begin
                        wb_valid <= 1'b1;
                        wb_en    <= ex_wb_en;
                        wb_err   <= 1'b0;
                        wb_rd    <= ex_rd;
                        wb_data  <= ex_result;
                    end else if (fault) begin
                        wb_valid <= 1'b1;
                        wb_en    <= 1'b0;
                        wb_err   <= 1'b1;
                        wb_rd    <= ex_rd;
                        wb_data  <= ex_result;
                    end else begin
                        mem_we    <= ex_is_st;
                        mem_addr  <= ex_result;
                        mem_wdata <= ex_store_data;
                        rd_q      <= ex_rd;
                    end
                end
            end else if (bus_done) begin
                // Timeout reports the faulting address; a completed store
                // reports its address, a completed load the returned data
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_err   <= ~mem_ack;
                wb_en    <= mem_ack & ~mem_we;
                wb_data  <= (mem_ack & ~mem_we) ? mem_rdata : mem_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, reset corner
// cases and randomized instructions against a transaction-level model.
// The bench acts as upstream execute stage and as the data memory.
module tb_mem_access_stage;

    localparam int DATA_W  = 32;
    localparam int RD_W    = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 1'b0;
    logic [DATA_W-1:0] ex_result = '0;
    logic [DATA_W-1:0] ex_store_data = '0;
    logic              ex_is_ld = 1'b0;
    logic              ex_is_st = 1'b0;
    logic [RD_W-1:0]   ex_rd = '0;
    logic              ex_wb_en = 1'b0;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              wb_valid;
    logic              wb_en;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_err;

    mem_access_stage #(
        .DATA_W  (DATA_W),
        .RD_W    (RD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_is_ld      (ex_is_ld),
        .ex_is_st      (ex_is_st),
        .ex_rd         (ex_rd),
        .ex_wb_en      (ex_wb_en),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_err        (wb_err)
    );

    always #5 clk = ~clk;

    // One instruction plus the bus behaviour and the expected writeback.
    // delay = BUS cycle on which the memory acks (> TIMEOUT means never).
    typedef struct {
        bit          ld;
        bit          st;
        logic [31:0] res;
        logic [31:0] sdata;
        logic [3:0]  rd;
        bit          wben;
        int          delay;
        logic [31:0] rdata;
        bit          e_err;
        bit          e_en;
        logic [31:0] e_data;
        int          e_cyc;   // cycles mem_req (and stall) stay high
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mem_model [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit ld, input bit st, input logic [31:0] res,
                                input logic [31:0] sdata, input logic [3:0] rd, input bit wben,
                                input int delay, input logic [31:0] rdata,
                                input bit e_err, input bit e_en, input logic [31:0] e_data,
                                input int e_cyc);
        vec_t v;
        v.ld = ld; v.st = st; v.res = res; v.sdata = sdata; v.rd = rd; v.wben = wben;
        v.delay = delay; v.rdata = rdata;
        v.e_err = e_err; v.e_en = e_en; v.e_data = e_data; v.e_cyc = e_cyc;
        return v;
    endfunction

    // Reference model: expected writeback from the instruction-level rules
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        if (!v.ld && !v.st) begin
            e.e_err = 0; e.e_en = v.wben; e.e_data = v.res; e.e_cyc = 0;
        end else if ((v.ld && v.st) || (v.res % 4 != 0)) begin
            e.e_err = 1; e.e_en = 0; e.e_data = v.res; e.e_cyc = 0;
        end else if (v.delay > TIMEOUT) begin
            e.e_err = 1; e.e_en = 0; e.e_data = v.res; e.e_cyc = TIMEOUT;
        end else begin
            e.e_err = 0; e.e_en = v.ld; e.e_data = v.ld ? v.rdata : v.res; e.e_cyc = v.delay;
        end
        return e;
    endfunction

    // Present one instruction at a post-edge point, play memory, await writeback
    task automatic run_instr(input vec_t v, input string tag);
        int  bus_n = 0;
        int  stall_n = 0;
        int  lat = 0;
        int  bad = 0;
        bit  got = 0;
        ex_valid = 1; ex_is_ld = v.ld; ex_is_st = v.st; ex_result = v.res;
        ex_store_data = v.sdata; ex_rd = v.rd; ex_wb_en = v.wben;
        for (int c = 0; c < TIMEOUT + 8 && !got; c++) begin
            if (mem_req) begin
                bus_n++;
                if (mem_addr !== v.res || mem_we !== v.st || mem_wdata !== v.sdata) bad++;
                if (bus_n == v.delay) begin
                    mem_ack = 1; mem_rdata = v.rdata;
                end
            end
            if (stall) stall_n++;
            @(posedge clk); #1;
            mem_ack = 0; mem_rdata = $urandom;
            lat++;
            if (wb_valid) got = 1;
            else if (stall) begin
                // junk from upstream while stalled must be ignored
                ex_valid = 1; ex_is_ld = 1'($urandom); ex_is_st = 1'($urandom);
                ex_result = $urandom; ex_store_data = $urandom; ex_rd = 4'($urandom);
            end
        end
        ex_valid = 0;
        check({tag, ".wb_seen"}, 64'(got), 64'd1);
        check({tag, ".latency"}, 64'(lat), 64'(v.e_cyc + 1));
        check({tag, ".wb_err"}, 64'(wb_err), 64'(v.e_err));
        check({tag, ".wb_en"}, 64'(wb_en), 64'(v.e_en));
        check({tag, ".wb_data"}, 64'(wb_data), 64'(v.e_data));
        if (!v.e_err) check({tag, ".wb_rd"}, 64'(wb_rd), 64'(v.rd));
        check({tag, ".req_cycles"}, 64'(bus_n), 64'(v.e_cyc));
        check({tag, ".stall_cycles"}, 64'(stall_n), 64'(v.e_cyc));
        if (v.e_cyc > 0) check({tag, ".bus_fields"}, 64'(bad), 64'd0);
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = mk(0, 0, 32'h10, 32'h0, 4'h1, 1, 0, 32'h0, 0, 1, 32'h10, 0);
        tbl[1] = mk(0, 0, 32'h20, 32'h0, 4'h2, 1, 0, 32'h0, 0, 1, 32'h20, 0);
        tbl[2] = mk(0, 0, 32'h30, 32'h0, 4'h3, 1, 0, 32'h0, 0, 1, 32'h30, 0);
        tbl[3] = mk(1, 0, 32'h100, 32'h0, 4'h4, 1, 3, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 3);
        tbl[4] = mk(0, 1, 32'h204, 32'h55, 4'h5, 0, 2, 32'h0, 0, 0, 32'h204, 2);
        tbl[5] = mk(1, 0, 32'h102, 32'h0, 4'h6, 1, 1, 32'h0, 1, 0, 32'h102, 0);
        tbl[6] = mk(1, 0, 32'h108, 32'h0, 4'h7, 1, 99, 32'h0, 1, 0, 32'h108, 16);
        tbl[7] = mk(1, 0, 32'h10C, 32'h0, 4'h8, 1, 16, 32'h12345678, 0, 1, 32'h12345678, 16);
        tbl[8] = mk(1, 1, 32'h110, 32'h9, 4'h9, 1, 1, 32'h0, 1, 0, 32'h110, 0);
        tbl[9] = mk(0, 0, 32'hFFFFFFFF, 32'h0, 4'hF, 0, 0, 32'h0, 0, 0, 32'hFFFFFFFF, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.stall", 64'(stall), 64'd0);
        check("rst.mem_req", 64'(mem_req), 64'd0);
        check("rst.mem_fields", {mem_we, mem_addr, mem_wdata[30:0]}, 64'd0);
        check("rst.wb_fields", {wb_valid, wb_en, wb_err, wb_rd, wb_data}, 64'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // Directed table (back-to-back ALU ops keep ex_valid high throughout)
        for (int i = 0; i < 10; i++) run_instr(tbl[i], $sformatf("tbl%0d", i));

        // Idle cycle: no pulse, wb fields hold
        @(posedge clk); #1;
        check("idle.wb_valid", 64'(wb_valid), 64'd0);
        check("idle.wb_data_hold", 64'(wb_data), 64'hFFFFFFFF);
        check("idle.wb_rd_hold", 64'(wb_rd), 64'hF);

        // Reset on BUS cycle 2 aborts the load without a writeback
        ex_valid = 1; ex_is_ld = 1; ex_is_st = 0; ex_result = 32'h100; ex_rd = 4'h2; ex_wb_en = 1;
        @(posedge clk); #1;
        ex_valid = 0;
        @(posedge clk); #1;
        check("rstbus.req_before", 64'(mem_req), 64'd1);
        rst_n = 0;
        @(posedge clk); #1;
        check("rstbus.mem_req", 64'(mem_req), 64'd0);
        check("rstbus.stall", 64'(stall), 64'd0);
        check("rstbus.wb_valid", 64'(wb_valid), 64'd0);
        rst_n = 1;
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;  // stray ack in IDLE is ignored
        begin
            int pulses = 0;
            int reqs = 0;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                mem_ack = 0;
                if (wb_valid) pulses++;
                if (mem_req) reqs++;
            end
            check("rstbus.no_wb", 64'(pulses), 64'd0);
            check("rstbus.no_req", 64'(reqs), 64'd0);
        end

        // Randomized instructions against the model, memory kept in mem_model
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        for (int n = 0; n < 150; n++) begin
            vec_t v;
            int kind = $urandom_range(0, 9);
            int idx = $urandom_range(0, 63);
            v.ld = (kind >= 4 && kind <= 6) || kind == 9;
            v.st = (kind >= 7);
            v.res = (v.ld || v.st) ? 32'h100 + 32'(idx * 4) : $urandom;
            if ((v.ld || v.st) && $urandom_range(0, 7) == 0) v.res = v.res + 32'($urandom_range(1, 3));
            v.sdata = $urandom;
            v.rd = 4'($urandom);
            v.wben = 1'($urandom);
            v.delay = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 4);
            v.rdata = mem_model[idx];
            v = model(v);
            run_instr(v, $sformatf("rnd%0d", n));
            if (v.st && !v.e_err) mem_model[idx] = v.sdata;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
